vga_sync_gen: RTL and testbench

Timing generator for the 640x480 VGA output path. It divides the system clock down to a pixel rate and runs horizontal and vertical counters. It produces hsync/vsync, a visible-area flag, and the current pixel coordinates. The column_o/row_o outputs feed the colour pattern generators directly, and the sync outputs go to the connector.

---
 rtl/vga_sync_gen_if.sv | 25 ++
 rtl/vga_sync_gen.sv | 111 +++++++++++
 tb/tb_vga_sync_gen.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/vga_sync_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : vga_sync_gen_if
// Description : Timing outputs of the VGA sync generator (coordinates, syncs,
//               visible flag, pixel enable and frame marker).
// Revision    : 1.0 - initial release
// ============================================================================
interface vga_sync_gen_if;
    logic [9:0] column_o;
    logic [9:0] row_o;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic       pixel_tick;
    logic       frame_start;

    modport master (
        output column_o, row_o, hsync, vsync, video_on, pixel_tick, frame_start
    );

    modport slave (
        input  column_o, row_o, hsync, vsync, video_on, pixel_tick, frame_start
    );
endinterface
`default_nettype wire

// File: rtl/vga_sync_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_sync_gen
// Description : Pixel-rate divider plus horizontal/vertical counters with
//               registered sync, visible-area and frame-start decodes.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_sync_gen #(
    parameter int CLK_DIV   = 2,
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter bit SYNC_POL  = 1'b0
) (
    input  wire logic       clk,
    input  wire logic       rst,
    vga_sync_gen_if.master  vga
);

    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [DIV_W-1:0] c_DIV_MAX  = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0]       c_H_MAX    = 10'(H_TOTAL - 1);
    localparam logic [9:0]       c_V_MAX    = 10'(V_TOTAL - 1);
    // 11-bit bounds so a range ending exactly at 1024 still compares correctly
    localparam logic [10:0]      c_H_VIS    = 11'(H_VISIBLE);
    localparam logic [10:0]      c_V_VIS    = 11'(V_VISIBLE);
    localparam logic [10:0]      c_HS_START = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0]      c_HS_END   = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0]      c_VS_START = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0]      c_VS_END   = 11'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [DIV_W-1:0] r_div;
    logic [9:0]       r_col;
    logic [9:0]       r_row;
    logic             r_hsync;
    logic             r_vsync;
    logic             r_video_on;
    logic             r_frame_start;

    logic             w_tick;
    logic             w_col_wrap;
    logic             w_row_wrap;
    logic [9:0]       w_col_nxt;
    logic [9:0]       w_row_nxt;
    logic             w_hs_act;
    logic             w_vs_act;
    logic             w_vis;

    // Gated by rst so the enable is low while held in reset, yet high in the
    // very first post-reset cycle when CLK_DIV is 1.
    assign w_tick     = ~rst && (r_div == c_DIV_MAX);
    assign w_col_wrap = (r_col == c_H_MAX);
    assign w_row_wrap = (r_row == c_V_MAX);

    always_comb begin
        w_col_nxt = r_col;
        w_row_nxt = r_row;
        if (w_tick) begin
            if (w_col_wrap) begin
                w_col_nxt = '0;
                w_row_nxt = w_row_wrap ? '0 : r_row + 10'd1;
            end else begin
                w_col_nxt = r_col + 10'd1;
            end
        end
    end

    // Decodes look at the next counter values so they line up with the
    // coordinates registered on the same edge.
    assign w_hs_act = ({1'b0, w_col_nxt} >= c_HS_START) && ({1'b0, w_col_nxt} < c_HS_END);
    assign w_vs_act = ({1'b0, w_row_nxt} >= c_VS_START) && ({1'b0, w_row_nxt} < c_VS_END);
    assign w_vis    = ({1'b0, w_col_nxt} < c_H_VIS) && ({1'b0, w_row_nxt} < c_V_VIS);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div         <= '0;
            r_col         <= '0;
            r_row         <= '0;
            r_hsync       <= ~SYNC_POL;
            r_vsync       <= ~SYNC_POL;
            r_video_on    <= 1'b1;
            r_frame_start <= 1'b0;
        end else begin
            r_div         <= (r_div == c_DIV_MAX) ? '0 : r_div + 1'b1;
            r_col         <= w_col_nxt;
            r_row         <= w_row_nxt;
            r_hsync       <= w_hs_act ? SYNC_POL : ~SYNC_POL;
            r_vsync       <= w_vs_act ? SYNC_POL : ~SYNC_POL;
            r_video_on    <= w_vis;
            r_frame_start <= w_tick && w_col_wrap && w_row_wrap;
        end
    end

    assign vga.column_o    = r_col;
    assign vga.row_o       = r_row;
    assign vga.hsync       = r_hsync;
    assign vga.vsync       = r_vsync;
    assign vga.video_on    = r_video_on;
    assign vga.pixel_tick  = w_tick;
    assign vga.frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_sync_gen
// Description : Bench for vga_sync_gen: default 640x480 build plus two reduced
//               geometries (CLK_DIV=2 active-low, CLK_DIV=1 active-high).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_sync_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vga_sync_gen_if ifa ();
    vga_sync_gen_if ifb ();
    vga_sync_gen_if ifc ();

    vga_sync_gen u_a (.clk(clk), .rst(rst), .vga(ifa));

    vga_sync_gen #(
        .CLK_DIV(2), .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .SYNC_POL(1'b0)
    ) u_b (.clk(clk), .rst(rst), .vga(ifb));

    vga_sync_gen #(
        .CLK_DIV(1), .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .SYNC_POL(1'b1)
    ) u_c (.clk(clk), .rst(rst), .vga(ifc));

    typedef struct {
        int col, row, hs, vs, vo, pt, fs;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];

    int checks = 0;
    int errors = 0;
    int n      = 0;   // non-reset edges since the last reset edge

    // Expected outputs from elapsed time: pixel index = n / d.
    function automatic exp_t model(int cnt, bit r_now, int d, int hv, int hf, int hsw, int hb,
                                   int vv, int vf, int vsw, int vb, bit pol);
        exp_t e;
        int ht = hv + hf + hsw + hb;
        int vt = vv + vf + vsw + vb;
        int p  = cnt / d;
        e.col = p % ht;
        e.row = (p / ht) % vt;
        e.hs  = (e.col >= hv + hf && e.col < hv + hf + hsw) ? (pol ? 1 : 0) : (pol ? 0 : 1);
        e.vs  = (e.row >= vv + vf && e.row < vv + vf + vsw) ? (pol ? 1 : 0) : (pol ? 0 : 1);
        e.vo  = (e.col < hv && e.row < vv) ? 1 : 0;
        e.pt  = (!r_now && (cnt % d == d - 1)) ? 1 : 0;
        e.fs  = (p > 0 && p % (ht * vt) == 0 && cnt % d == 0) ? 1 : 0;
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at n=%0d: observed %0d expected %0d", tag, n, obs, exp);
        end
    endtask

    task automatic cmp(input string who, input exp_t e, input logic [9:0] col, input logic [9:0] row,
                       input logic hs, input logic vs, input logic vo, input logic pt, input logic fs);
        check({who, ".column_o"},    {22'd0, col}, e.col);
        check({who, ".row_o"},       {22'd0, row}, e.row);
        check({who, ".hsync"},       {31'd0, hs},  e.hs);
        check({who, ".vsync"},       {31'd0, vs},  e.vs);
        check({who, ".video_on"},    {31'd0, vo},  e.vo);
        check({who, ".pixel_tick"},  {31'd0, pt},  e.pt);
        check({who, ".frame_start"}, {31'd0, fs},  e.fs);
    endtask

    // One clk: advance the time model, set rst for this cycle, compare mid-cycle.
    task automatic step(input bit r);
        exp_t ea, eb, ec;
        @(posedge clk);
        n = rst ? 0 : n + 1;
        #1 rst = r;
        qa.push_back(model(n, rst, 2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0));
        qb.push_back(model(n, rst, 2, 16, 2, 3, 3, 6, 1, 2, 1, 1'b0));
        qc.push_back(model(n, rst, 1, 16, 2, 3, 3, 6, 1, 2, 1, 1'b1));
        @(negedge clk);
        ea = qa.pop_front();
        eb = qb.pop_front();
        ec = qc.pop_front();
        cmp("A", ea, ifa.column_o, ifa.row_o, ifa.hsync, ifa.vsync, ifa.video_on, ifa.pixel_tick, ifa.frame_start);
        cmp("B", eb, ifb.column_o, ifb.row_o, ifb.hsync, ifb.vsync, ifb.video_on, ifb.pixel_tick, ifb.frame_start);
        cmp("C", ec, ifc.column_o, ifc.row_o, ifc.hsync, ifc.vsync, ifc.video_on, ifc.pixel_tick, ifc.frame_start);
    endtask

    int a_ticks = 0, a_hlow = 0, a_von = 0, a_first_tick = -1;
    int b_fs = 0, b_first_fs = -1, c_fs = 0;

    initial begin
        // Reset held for 5 clk
        for (int i = 0; i < 5; i++) step(1'b1);

        // Run into B's second frame, then reset inside its hsync+vsync (row 7, col 19)
        for (int i = 0; i < 854; i++) step(1'b0);
        step(1'b1);
        step(1'b1);
        step(1'b1);

        // Reset exactly on the cycle before B and C would raise frame_start
        for (int i = 0; i < 479; i++) step(1'b0);
        step(1'b1);
        step(1'b1);

        // Final release: line timing on A, frame period on B and C
        for (int i = 0; i < 2000; i++) begin
            step(1'b0);
            if (n < 1600) begin
                if (ifa.pixel_tick) begin
                    a_ticks++;
                    if (a_first_tick < 0) a_first_tick = n;
                end
                if (!ifa.hsync)  a_hlow++;
                if (ifa.video_on) a_von++;
            end
            if (ifb.frame_start) begin
                b_fs++;
                if (b_first_fs < 0) b_first_fs = n;
            end
            if (ifc.frame_start) c_fs++;
        end

        check("A.ticks_per_line",     a_ticks,      800);
        check("A.hsync_low_clks",     a_hlow,       192);
        check("A.video_on_clks_line", a_von,        1280);
        check("A.first_tick_n",       a_first_tick, 1);
        check("B.frame_start_count",  b_fs,         4);
        check("B.first_frame_start",  b_first_fs,   480);
        check("C.frame_start_count",  c_fs,         8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
